// File: rtl/lcu_rr_sched.sv
// lcu_rr_sched -- round-robin owner scheduler for one shared LCU FSM.
//
// One requester at a time owns the shared FSM for a bounded burst of steps.
// Between owners the FSM is held in reset, so each new owner starts from the
// initial state. While a requester owns the unit, its input vector is steered
// to the FSM. Each step's Mealy output is returned, tagged with the owner id.
//
// Ports
//   clk         clock; control state changes on the rising edge, and the FSM
//               output is captured on the falling edge
//   rst         asynchronous, active-high reset
//   req         per-requester ownership request; for the owner it also
//               qualifies each step
//   req_x       packed input vectors, requester i at [i*XW +: XW]
//   req_last    per-requester "this step ends my burst"
//   gnt         one-hot ownership (registered)
//   lcu_rst     reset to the shared FSM (registered, high outside RUN)
//   lcu_x       input vector to the shared FSM (owner's slice in RUN, else 0)
//   lcu_y       Mealy outputs from the shared FSM
//   resp_valid  one-cycle pulse per completed step
//   resp_id     owner of the reported step
//   resp_y      Mealy output captured during the step
//   resp_last   the reported step closed the burst
//   abort       one-cycle pulse: owner dropped req mid-burst
//   busy        scheduler is not idle
module lcu_rr_sched #(
  parameter int N_REQ     = 4,
  parameter int XW        = 15,
  parameter int YW        = 23,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*XW-1:0]        req_x,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           gnt,
  output logic                       lcu_rst,
  output logic [XW-1:0]              lcu_x,
  input  logic [YW-1:0]              lcu_y,
  output logic                       resp_valid,
  output logic [$clog2(N_REQ)-1:0]   resp_id,
  output logic [YW-1:0]              resp_y,
  output logic                       resp_last,
  output logic                       abort,
  output logic                       busy
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_RUN   = 2'd2,
    ST_REL   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   own_q, own_d;
  logic [7:0]      count_q, count_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic            lcu_rst_q, lcu_rst_d;
  logic            resp_valid_q, resp_valid_d;
  logic [IW-1:0]   resp_id_q, resp_id_d;
  logic [YW-1:0]   resp_y_q, resp_y_d;
  logic            resp_last_q, resp_last_d;
  logic            abort_q, abort_d;
  logic [YW-1:0]   y_hold_q;

  // Unpacked view of the requester input vectors.
  logic [XW-1:0]   x_arr [N_REQ];

  // Candidate i is (rr_ptr + i) mod N_REQ; scanning candidates in order gives
  // "first set bit at or after rr_ptr, wrapping".
  logic [IW:0]     cand_sum [N_REQ];
  logic [IW-1:0]   cand_idx [N_REQ];

  logic [N_REQ-1:0] own_d_onehot;
  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic            burst_end;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_per_req
      assign x_arr[gi]        = req_x[gi*XW +: XW];
      assign cand_sum[gi]     = {1'b0, rr_ptr_q} + (IW+1)'(gi);
      assign cand_idx[gi]     = (cand_sum[gi] >= (IW+1)'(N_REQ))
                                ? IW'(cand_sum[gi] - (IW+1)'(N_REQ))
                                : IW'(cand_sum[gi]);
      assign own_d_onehot[gi] = (own_d == IW'(gi));
    end
  endgenerate

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!pick_found && req[cand_idx[k]]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx[k];
      end
    end
  end

  // The step being reported now is step number count_q+1 of the burst.
  assign burst_end = (({1'b0, count_q} + 9'd1) == 9'(MAX_BURST));

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    own_d        = own_q;
    count_d      = count_q;
    resp_valid_d = 1'b0;
    resp_id_d    = resp_id_q;
    resp_y_d     = resp_y_q;
    resp_last_d  = 1'b0;
    abort_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          own_d   = pick_idx;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        count_d = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (req[own_q]) begin
          resp_valid_d = 1'b1;
          resp_id_d    = own_q;
          resp_y_d     = y_hold_q;
          count_d      = count_q + 8'd1;
          if (req_last[own_q] || burst_end) begin
            resp_last_d = 1'b1;
            state_d     = ST_REL;
          end
        end else begin
          // The FSM already moved on this cycle's falling edge; that state is
          // thrown away by holding it in reset from REL onwards.
          abort_d = 1'b1;
          state_d = ST_REL;
        end
      end
      ST_REL: begin
        rr_ptr_d = (own_q == IW'(N_REQ-1)) ? '0 : own_q + 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // gnt and lcu_rst are registered, so they follow the state being entered.
    gnt_d     = ((state_d == ST_GRANT) || (state_d == ST_RUN)) ? own_d_onehot : '0;
    lcu_rst_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      own_q        <= '0;
      count_q      <= '0;
      gnt_q        <= '0;
      lcu_rst_q    <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_y_q     <= '0;
      resp_last_q  <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      own_q        <= own_d;
      count_q      <= count_d;
      gnt_q        <= gnt_d;
      lcu_rst_q    <= lcu_rst_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_y_q     <= resp_y_d;
      resp_last_q  <= resp_last_d;
      abort_q      <= abort_d;
    end
  end

  // The shared FSM updates on the falling edge; sampling lcu_y on that same
  // edge captures the Mealy output of the transition being taken.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      y_hold_q <= '0;
    end else if (state_q == ST_RUN) begin
      y_hold_q <= lcu_y;
    end
  end

  always_comb begin
    lcu_x = '0;
    if (state_q == ST_RUN) begin
      lcu_x = x_arr[own_q];
    end
  end

  assign gnt        = gnt_q;
  assign lcu_rst    = lcu_rst_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_y     = resp_y_q;
  assign resp_last  = resp_last_q;
  assign abort      = abort_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lcu_rr_sched.sv
// Testbench for lcu_rr_sched. A small stand-in for the shared LCU FSM supplies
// lcu_y: falling-edge state update, asynchronous reset from lcu_rst, and only
// the transitions the directed vectors need:
//   s1: x1&x15 -> y2,y3 (23'h000006), go s2; otherwise y=0, stay s1
//   s2: x15&!x1 -> y2,y4 (23'h00000A), go s4; otherwise y5 (23'h000010), go s1
//   s4: y24 (23'h400000), go s1
module tb_lcu_rr_sched;

  localparam int N_REQ     = 4;
  localparam int XW        = 15;
  localparam int YW        = 23;
  localparam int MAX_BURST = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N_REQ-1:0]     req = '0;
  logic [N_REQ*XW-1:0]  req_x = '0;
  logic [N_REQ-1:0]     req_last = '0;
  logic [N_REQ-1:0]     gnt;
  logic                 lcu_rst;
  logic [XW-1:0]        lcu_x;
  logic [YW-1:0]        lcu_y;
  logic                 resp_valid;
  logic [1:0]           resp_id;
  logic [YW-1:0]        resp_y;
  logic                 resp_last;
  logic                 abort;
  logic                 busy;

  int n_tests = 0;
  int n_fail  = 0;

  lcu_rr_sched #(
    .N_REQ(N_REQ), .XW(XW), .YW(YW), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_x(req_x), .req_last(req_last),
    .gnt(gnt), .lcu_rst(lcu_rst), .lcu_x(lcu_x), .lcu_y(lcu_y),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_y(resp_y),
    .resp_last(resp_last), .abort(abort), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- LCU stand-in ----------------
  logic [1:0] st_q, st_next;

  always_comb begin
    st_next = 2'd0;
    lcu_y   = '0;
    case (st_q)
      2'd0: if (lcu_x[0] && lcu_x[14]) begin lcu_y = 23'h000006; st_next = 2'd1; end
      2'd1: begin
        if (lcu_x[14] && !lcu_x[0]) begin lcu_y = 23'h00000A; st_next = 2'd2; end
        else                        begin lcu_y = 23'h000010; st_next = 2'd0; end
      end
      2'd2: begin lcu_y = 23'h400000; st_next = 2'd0; end
      default: begin lcu_y = '0; st_next = 2'd0; end
    endcase
  end

  always_ff @(negedge clk or posedge lcu_rst) begin
    if (lcu_rst) st_q <= 2'd0;
    else         st_q <= st_next;
  end

  // One line per reported step.
  always @(negedge clk) begin
    if (resp_valid)
      $display("[TB] t=%0t resp id=%0d y=%h last=%0d", $time, resp_id, resp_y, resp_last);
  end

  // ---------------- helpers ----------------
  typedef struct {
    int           id;
    logic [14:0]  x;
    logic [22:0]  exp_y;
  } vec_t;

  typedef struct {
    logic [3:0]   gnt;
    logic         lrst;
    logic         rv;
    logic [22:0]  y;
    logic         last;
    logic         ab;
    logic [1:0]   id;
  } cyc_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic chk_cyc(input string nm, input int c, input cyc_t e);
    chk($sformatf("%s[%0d].gnt", nm, c),        32'(gnt),        32'(e.gnt));
    chk($sformatf("%s[%0d].lcu_rst", nm, c),    32'(lcu_rst),    32'(e.lrst));
    chk($sformatf("%s[%0d].resp_valid", nm, c), 32'(resp_valid), 32'(e.rv));
    chk($sformatf("%s[%0d].resp_last", nm, c),  32'(resp_last),  32'(e.last));
    chk($sformatf("%s[%0d].abort", nm, c),      32'(abort),      32'(e.ab));
    if (e.rv) begin
      chk($sformatf("%s[%0d].resp_y", nm, c),  32'(resp_y),  32'(e.y));
      chk($sformatf("%s[%0d].resp_id", nm, c), 32'(resp_id), 32'(e.id));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // One-step burst (req_last set) from IDLE for requester id. Non-owner slices
  // carry the complement of x so a wrong steering choice changes lcu_y.
  task automatic run_single(input string nm, input int id, input logic [14:0] x,
                            input logic [22:0] exp_y);
    logic [14:0] nx;
    nx = ~x;
    req_x = {4{nx}};
    req_x[id*XW +: XW] = x;
    req      = 4'(1 << id);
    req_last = 4'(1 << id);
    tick();  // GRANT
    chk({nm, ".grant.gnt"},     32'(gnt),     32'(1 << id));
    chk({nm, ".grant.lcu_rst"}, 32'(lcu_rst), 32'd1);
    chk({nm, ".grant.busy"},    32'(busy),    32'd1);
    tick();  // RUN (the step cycle)
    chk({nm, ".run.gnt"},       32'(gnt),     32'(1 << id));
    chk({nm, ".run.lcu_rst"},   32'(lcu_rst), 32'd0);
    chk({nm, ".run.lcu_x"},     32'(lcu_x),   32'(x));
    tick();  // REL, response visible
    chk({nm, ".resp_valid"},    32'(resp_valid), 32'd1);
    chk({nm, ".resp_y"},        32'(resp_y),     32'(exp_y));
    chk({nm, ".resp_id"},       32'(resp_id),    32'(id));
    chk({nm, ".resp_last"},     32'(resp_last),  32'd1);
    chk({nm, ".rel.gnt"},       32'(gnt),        32'd0);
    chk({nm, ".rel.lcu_rst"},   32'(lcu_rst),    32'd1);
    req      = '0;
    req_last = '0;
    tick();  // IDLE
    chk({nm, ".idle.resp_valid"}, 32'(resp_valid), 32'd0);
    chk({nm, ".idle.busy"},       32'(busy),       32'd0);
  endtask

  // ---------------- stimulus ----------------
  vec_t vecs[5];
  cyc_t burst_tab[12];
  cyc_t abort_tab[9];

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 15'h4001, 23'h000006};
    vecs[1] = '{1, 15'h4001, 23'h000006};
    vecs[2] = '{2, 15'h0001, 23'h000000};
    vecs[3] = '{3, 15'h4001, 23'h000006};
    vecs[4] = '{2, 15'h4001, 23'h000006};

    //               gnt    lrst  rv    y            last  ab    id
    burst_tab[0]  = '{4'h8, 1'b1, 1'b0, 23'h000000, 1'b0, 1'b0, 2'd3};
    burst_tab[1]  = '{4'h8, 1'b0, 1'b0, 23'h000000, 1'b0, 1'b0, 2'd3};
    burst_tab[2]  = '{4'h8, 1'b0, 1'b1, 23'h000006, 1'b0, 1'b0, 2'd3};
    burst_tab[3]  = '{4'h8, 1'b0, 1'b1, 23'h000010, 1'b0, 1'b0, 2'd3};
    burst_tab[4]  = '{4'h8, 1'b0, 1'b1, 23'h000006, 1'b0, 1'b0, 2'd3};
    burst_tab[5]  = '{4'h0, 1'b1, 1'b1, 23'h000010, 1'b1, 1'b0, 2'd3};
    burst_tab[6]  = '{4'h0, 1'b1, 1'b0, 23'h000000, 1'b0, 1'b0, 2'd3};
    burst_tab[7]  = '{4'h8, 1'b1, 1'b0, 23'h000000, 1'b0, 1'b0, 2'd3};
    burst_tab[8]  = '{4'h8, 1'b0, 1'b0, 23'h000000, 1'b0, 1'b0, 2'd3};
    burst_tab[9]  = '{4'h8, 1'b0, 1'b1, 23'h000006, 1'b0, 1'b0, 2'd3};
    burst_tab[10] = '{4'h0, 1'b1, 1'b0, 23'h000000, 1'b0, 1'b1, 2'd3};
    burst_tab[11] = '{4'h0, 1'b1, 1'b0, 23'h000000, 1'b0, 1'b0, 2'd3};

    abort_tab[0]  = '{4'h4, 1'b1, 1'b0, 23'h000000, 1'b0, 1'b0, 2'd2};
    abort_tab[1]  = '{4'h4, 1'b0, 1'b0, 23'h000000, 1'b0, 1'b0, 2'd2};
    abort_tab[2]  = '{4'h4, 1'b0, 1'b1, 23'h000006, 1'b0, 1'b0, 2'd2};
    abort_tab[3]  = '{4'h0, 1'b1, 1'b0, 23'h000000, 1'b0, 1'b1, 2'd2};
    abort_tab[4]  = '{4'h0, 1'b1, 1'b0, 23'h000000, 1'b0, 1'b0, 2'd2};
    abort_tab[5]  = '{4'h1, 1'b1, 1'b0, 23'h000000, 1'b0, 1'b0, 2'd0};
    abort_tab[6]  = '{4'h1, 1'b0, 1'b0, 23'h000000, 1'b0, 1'b0, 2'd0};
    abort_tab[7]  = '{4'h0, 1'b1, 1'b1, 23'h000006, 1'b1, 1'b0, 2'd0};
    abort_tab[8]  = '{4'h0, 1'b1, 1'b0, 23'h000000, 1'b0, 1'b0, 2'd0};

    // Reset values while rst is held.
    tick();
    tick();
    chk("rst.gnt",        32'(gnt),        32'd0);
    chk("rst.lcu_rst",    32'(lcu_rst),    32'd1);
    chk("rst.lcu_x",      32'(lcu_x),      32'd0);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.resp_id",    32'(resp_id),    32'd0);
    chk("rst.resp_y",     32'(resp_y),     32'd0);
    chk("rst.resp_last",  32'(resp_last),  32'd0);
    chk("rst.abort",      32'(abort),      32'd0);
    chk("rst.busy",       32'(busy),       32'd0);
    rst = 1'b0;
    tick();

    // Single-step bursts to each requester.
    for (int i = 0; i < 5; i++)
      run_single($sformatf("single%0d", i), vecs[i].id, vecs[i].x, vecs[i].exp_y);

    // Two-step burst on requester 1: s1 -> s2 -> s4.
    req_x = '0;
    req_x[1*XW +: XW] = 15'h4001;
    req      = 4'b0010;
    req_last = 4'b0000;
    tick();  // GRANT
    chk("two.grant.gnt", 32'(gnt), 32'h2);
    tick();  // RUN step 1
    chk("two.run1.lcu_rst", 32'(lcu_rst), 32'd0);
    tick();  // RUN step 2, step 1 reported
    chk("two.r1.valid",   32'(resp_valid), 32'd1);
    chk("two.r1.y",       32'(resp_y),     32'h000006);
    chk("two.r1.last",    32'(resp_last),  32'd0);
    chk("two.r1.lcu_rst", 32'(lcu_rst),    32'd0);
    req_x[1*XW +: XW] = 15'h4000;
    req_last = 4'b0010;
    tick();  // REL, step 2 reported
    chk("two.r2.valid",   32'(resp_valid), 32'd1);
    chk("two.r2.y",       32'(resp_y),     32'h00000A);
    chk("two.r2.id",      32'(resp_id),    32'd1);
    chk("two.r2.last",    32'(resp_last),  32'd1);
    chk("two.r2.lcu_rst", 32'(lcu_rst),    32'd1);
    req      = '0;
    req_last = '0;
    tick();  // IDLE

    // Round robin between requesters 0 and 2, one-step bursts, from reset.
    do_reset();
    req_x    = {4{15'h4001}};
    req      = 4'b0101;
    req_last = 4'b0101;
    tick();  // first GRANT
    for (int c = 0; c < 15; c++) begin
      int ph;
      int g;
      ph = c % 4;
      g  = ((c / 4) % 2 == 1) ? 2 : 0;
      chk($sformatf("rr[%0d].gnt", c),        32'(gnt),        (ph < 2) ? 32'(1 << g) : 32'd0);
      chk($sformatf("rr[%0d].lcu_rst", c),    32'(lcu_rst),    (ph != 1) ? 32'd1 : 32'd0);
      chk($sformatf("rr[%0d].resp_valid", c), 32'(resp_valid), (ph == 2) ? 32'd1 : 32'd0);
      if (ph == 2)
        chk($sformatf("rr[%0d].resp_id", c), 32'(resp_id), 32'(g));
      if (c == 14) begin
        req      = '0;
        req_last = '0;
      end
      tick();
    end
    chk("rr.end.busy", 32'(busy), 32'd0);

    // Burst cap on requester 3, then regrant restarts the FSM, then abort.
    req_x    = {4{15'h4001}};
    req      = 4'b1000;
    req_last = 4'b0000;
    tick();
    for (int c = 0; c < 12; c++) begin
      chk_cyc("burst", c, burst_tab[c]);
      if (c == 9) req = '0;
      tick();
    end

    // Abort on requester 2, then rr_ptr=3 makes 0 win over 2.
    req      = 4'b0100;
    req_last = 4'b0000;
    tick();
    for (int c = 0; c < 9; c++) begin
      chk_cyc("abort", c, abort_tab[c]);
      if (c == 2) req = '0;
      if (c == 4) begin
        req      = 4'b0101;
        req_last = 4'b0101;
      end
      if (c == 7) begin
        req      = '0;
        req_last = '0;
      end
      tick();
    end

    // Reset mid-burst (rr_ptr is 1 beforehand, so 3 would win without reset).
    req      = 4'b1000;
    req_last = 4'b0000;
    tick();  // GRANT
    chk("mrst.grant.gnt", 32'(gnt), 32'h8);
    tick();  // RUN
    tick();  // RUN, step reported
    chk("mrst.pre.valid", 32'(resp_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("mrst.gnt",        32'(gnt),        32'd0);
    chk("mrst.lcu_rst",    32'(lcu_rst),    32'd1);
    chk("mrst.resp_valid", 32'(resp_valid), 32'd0);
    chk("mrst.busy",       32'(busy),       32'd0);
    tick();
    tick();
    rst      = 1'b0;
    req      = 4'b1001;
    req_last = 4'b1001;
    tick();  // GRANT
    chk("mrst.regrant.gnt", 32'(gnt), 32'h1);
    tick();  // RUN
    tick();  // REL, response
    chk("mrst.resp.valid", 32'(resp_valid), 32'd1);
    chk("mrst.resp.id",    32'(resp_id),    32'd0);
    chk("mrst.resp.y",     32'(resp_y),     32'h000006);
    chk("mrst.resp.last",  32'(resp_last),  32'd1);
    req      = '0;
    req_last = '0;
    tick();
    chk("mrst.end.busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lcu_rr_sched.md
# lcu_rr_sched

Round-robin scheduler that time-shares one logic-control-unit FSM instance (15 control inputs, 23 Mealy outputs, asynchronous active-high reset, state update on the falling clock edge) among N_REQ requesters. It grants ownership for a bounded burst and holds the shared FSM in reset between owners, so every owner starts from the initial state. While a requester owns the unit, the scheduler steers that requester's input vector to the FSM and returns each step's Mealy output tagged with the owner id.

## Interface
- N_REQ, 4, number of requesters (2..8)
- XW, 15, FSM input width; lcu_x[0]=x1 … lcu_x[14]=x15
- YW, 23, FSM output width; lcu_y[0..18]=y1..y19, lcu_y[19..22]=y21..y24
- MAX_BURST, 4, maximum steps per grant (1..255)

- clk  in  1  clock; control on rising edge, output capture on falling edge
- rst  in  1  reset, asynchronous, active-high
- req  in  N_REQ  per-requester ownership request / step qualifier
- req_x  in  N_REQ*XW  input vectors; requester i uses slice [i*XW +: XW]
- req_last  in  N_REQ  marks the final step of the owner's burst
- gnt  out  N_REQ  one-hot ownership, registered
- lcu_rst  out  1  drives shared FSM reset, registered
- lcu_x  out  XW  drives shared FSM inputs (combinational mux)
- lcu_y  in  YW  shared FSM Mealy outputs
- resp_valid  out  1  one-cycle pulse per completed step
- resp_id  out  clog2(N_REQ)  owner of the step
- resp_y  out  YW  Mealy output of the step
- resp_last  out  1  step ended the burst (req_last or MAX_BURST)
- abort  out  1  one-cycle pulse: owner dropped req mid-burst
- busy  out  1  state != IDLE

## Operation
- States: IDLE, GRANT, RUN, REL.
  - All state registers update on the rising edge.
  - lcu_rst=1 in every state except RUN.
- IDLE: gnt=0, lcu_x=0. If any req bit is set, select the first set bit at or after rr_ptr (wrapping), latch it into own, and go to GRANT.
- GRANT: one cycle. gnt[own]=1, lcu_rst=1, step count cleared. Next state is RUN.
- RUN: gnt[own]=1, lcu_rst=0, lcu_x=req_x slice of own.
  - A cycle with req[own]=1 is a step. The FSM transitions on that cycle's falling edge.
  - On the same falling edge, the scheduler captures lcu_y into a holding register.
  - At the next rising edge: resp_valid=1, resp_y=captured value, resp_id=own, and count increments.
  - If req_last[own]=1 or count+1==MAX_BURST, the step also sets resp_last=1 and the next state is REL.
  - A cycle with req[own]=0 is an abort: no resp_valid, abort pulses, next state is REL. The FSM state reached in that cycle is discarded.
- REL: gnt=0, lcu_rst=1, rr_ptr=(own+1) mod N_REQ. Next state is IDLE.
- req bits of non-owners are ignored during GRANT, RUN and REL. Requests are never queued; arbitration is re-evaluated only in IDLE.
- Requesters must hold req_x stable from the rising edge to the falling edge of each step cycle.
- rst mid-operation: every register returns to its reset value immediately. lcu_rst rises asynchronously, and in-flight resp is lost.
- Reset values:
  - state=IDLE, rr_ptr=0, own=0, count=0
  - gnt=0, lcu_rst=1, lcu_x=0
  - resp_valid=0, resp_id=0, resp_y=0, resp_last=0, abort=0, busy=0

## Timing
- Request to first step: req seen at edge T (IDLE), then GRANT during T..T+1, then RUN from T+1. The first step's response is valid at T+2.
- Step latency: resp_valid rises one cycle after the step cycle begins, and is asserted back-to-back for consecutive steps.
- Handover: the last step at cycle k is followed by REL at k+1, IDLE at k+2, and GRANT at k+3 at the earliest. This guarantees at least 3 cycles of lcu_rst=1 between owners.
- Burst: at most MAX_BURST resp_valid pulses per grant, with resp_last on the final one.
- Simultaneous req_last and burst limit: a single resp_last and a single release.
- rr_ptr wraps from N_REQ-1 to 0.

## Test plan
- Single step: assert rst, then req[0]=1 with req_x[0]=15'h4001 (x15, x1) and req_last[0]=1. Expect gnt=4'b0001 for 2 cycles, then one resp_valid with resp_y=23'h000006 (y2,y3), resp_id=0, resp_last=1, then REL and IDLE.
- Two-step sequence: owner 1 sends 15'h4001 then 15'h4000 with last on step 2. Expect resp_y 23'h000006 then 23'h00000A (y2,y4, s2 to s4), with lcu_rst=0 throughout RUN.
- Round robin: from reset, req=4'b0101 held, each burst of 1 step. Expect grant order 0, 2, 0, 2, and a 3-cycle lcu_rst=1 gap between grants.
- Burst cap: MAX_BURST=4, req[3] held with req_last=0. Expect exactly 4 resp_valid pulses, resp_last on the 4th, then a regrant to 3. The first resp after regrant is 23'h000006 for input 15'h4001 (FSM restarted).
- Abort: drop req[2] on the 2nd RUN cycle. Expect 1 resp_valid, an abort pulse, no resp_last, rr_ptr=3, and FSM held in reset.
- Reset mid-burst: assert rst during RUN. Expect gnt=0, lcu_rst=1, resp_valid=0 immediately (asynchronous), and resumption from rr_ptr=0 after release.
